// File: rtl/sec_line_mem_responder.sv
// Memory-side responder for the blocking cache line interface: one 128-bit line request
// at a time, fixed latency, with a secure region that non-secure requesters cannot touch.
module sec_line_mem_responder #(
    parameter int p_opaque_nbits = 8,
    parameter int p_addr_nbits   = 32,
    parameter int p_data_nbits   = 128,
    parameter int p_num_lines    = 64,
    parameter int p_secure_lines = 16,
    parameter int p_latency      = 2
) (
    input  logic                                                     clk,
    input  logic                                                     reset,
    input  logic [3+p_opaque_nbits+p_addr_nbits+4+p_data_nbits-1:0] memreq_msg,
    input  logic                                                     memreq_domain,
    input  logic                                                     memreq_val,
    output logic                                                     memreq_rdy,
    output logic [3+p_opaque_nbits+4+p_data_nbits-1:0]               memresp_msg,
    output logic                                                     memresp_domain,
    output logic                                                     memresp_val,
    input  logic                                                     memresp_rdy,
    output logic                                                     violation,
    output logic [7:0]                                               viol_count
);

    localparam int c_LEN_W = 4;
    localparam int c_IDX_W = $clog2(p_num_lines);
    localparam int c_CNT_W = (p_latency > 2) ? $clog2(p_latency) : 1;
    localparam int c_A_LSB = p_data_nbits + c_LEN_W;
    localparam int c_O_LSB = c_A_LSB + p_addr_nbits;
    localparam int c_T_LSB = c_O_LSB + p_opaque_nbits;
    localparam logic [c_IDX_W:0]   c_SEC  = (c_IDX_W+1)'(p_secure_lines);
    localparam logic [c_CNT_W-1:0] c_LOAD = c_CNT_W'(p_latency - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]                r_state;
    logic [c_CNT_W-1:0]        r_cnt;
    logic [2:0]                r_type;
    logic [p_opaque_nbits-1:0] r_opaque;
    logic [c_IDX_W-1:0]        r_idx;
    logic [p_data_nbits-1:0]   r_data;
    logic                      r_domain;
    logic [3+p_opaque_nbits+c_LEN_W+p_data_nbits-1:0] r_resp_msg;
    logic                      r_resp_domain;
    logic                      r_violation;
    logic [7:0]                r_viol_count;
    logic [p_data_nbits-1:0]   r_mem [p_num_lines];

    logic [2:0]                w_req_type;
    logic [p_opaque_nbits-1:0] w_req_opaque;
    logic [p_addr_nbits-1:0]   w_req_addr;
    logic [p_data_nbits-1:0]   w_req_data;
    logic                      w_unused_bits;
    logic                      w_accept;
    logic                      w_commit;
    logic [2:0]                w_c_type;
    logic [p_opaque_nbits-1:0] w_c_opaque;
    logic [c_IDX_W-1:0]        w_c_idx;
    logic [p_data_nbits-1:0]   w_c_data;
    logic                      w_c_domain;
    logic                      w_denied;
    logic                      w_wr;
    logic [p_data_nbits-1:0]   w_rd_data;

    assign w_req_type    = memreq_msg[c_T_LSB +: 3];
    assign w_req_opaque  = memreq_msg[c_O_LSB +: p_opaque_nbits];
    assign w_req_addr    = memreq_msg[c_A_LSB +: p_addr_nbits];
    assign w_req_data    = memreq_msg[0 +: p_data_nbits];
    // Byte offset, upper address bits and len never affect a full-line access.
    assign w_unused_bits = ^{w_req_addr, memreq_msg[p_data_nbits +: c_LEN_W]};

    assign memreq_rdy = (r_state == S_IDLE);
    assign w_accept   = memreq_rdy && memreq_val && reset;

    // Single-cycle latency commits straight from the incoming request at the accept edge.
    assign w_commit   = (p_latency == 1) ? w_accept
                                         : ((r_state == S_WAIT) && (r_cnt == c_CNT_W'(1)));
    assign w_c_type   = (p_latency == 1) ? w_req_type    : r_type;
    assign w_c_opaque = (p_latency == 1) ? w_req_opaque  : r_opaque;
    assign w_c_idx    = (p_latency == 1) ? w_req_addr[4 +: c_IDX_W] : r_idx;
    assign w_c_data   = (p_latency == 1) ? w_req_data    : r_data;
    assign w_c_domain = (p_latency == 1) ? memreq_domain : r_domain;

    assign w_denied  = w_c_domain && ({1'b0, w_c_idx} < c_SEC);
    assign w_wr      = w_commit && !w_denied && (w_c_type == 3'd1);
    assign w_rd_data = (!w_denied && (w_c_type == 3'd0)) ? r_mem[w_c_idx] : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_type        <= '0;
            r_opaque      <= '0;
            r_idx         <= '0;
            r_data        <= '0;
            r_domain      <= 1'b0;
            r_resp_msg    <= '0;
            r_resp_domain <= 1'b0;
            r_violation   <= 1'b0;
            r_viol_count  <= '0;
        end else begin
            r_violation <= 1'b0;
            case (r_state)
                S_IDLE: if (w_accept) begin
                    r_type   <= w_req_type;
                    r_opaque <= w_req_opaque;
                    r_idx    <= w_req_addr[4 +: c_IDX_W];
                    r_data   <= w_req_data;
                    r_domain <= memreq_domain;
                    r_cnt    <= c_LOAD;
                    r_state  <= (p_latency == 1) ? S_RESP : S_WAIT;
                end
                S_WAIT: begin
                    r_cnt <= r_cnt - 1'b1;
                    if (w_commit) r_state <= S_RESP;
                end
                S_RESP: if (memresp_rdy) r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
            if (w_commit) begin
                r_resp_msg    <= {w_c_type, w_c_opaque, {c_LEN_W{1'b0}}, w_rd_data};
                r_resp_domain <= w_c_domain;
                r_violation   <= w_denied;
                if (w_denied && (r_viol_count != 8'hFF))
                    r_viol_count <= r_viol_count + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[w_c_idx] <= w_c_data;
    end

    assign memresp_msg    = r_resp_msg;
    assign memresp_domain = r_resp_domain;
    assign memresp_val    = (r_state == S_RESP);
    assign violation      = r_violation;
    assign viol_count     = r_viol_count;

endmodule
